ext_tran_master: RTL
====================

Name: ext_tran_master

Overview:
Converts the host-programmed single transaction (start/write/clear/size/addr/data) into one Wishbone classic master cycle on the SoC bus. Sits between the host register bridge and the SoC interconnect, and is the master selected when the bus-master selector picks the external port. Handles byte-lane steering and alignment checking, and holds a sticky ready/error status until the host clears it.

Parameters:
ADDR_WIDTH, 32, width of the transaction address and of wb_adr_o.
DATA_WIDTH, 32, width of the data bus. Fixed at 32; sel is 4 bits.
TIMEOUT_CYCLES, 255, bus cycles allowed before abort. Used only with EXT_TRAN_TIMEOUT_EN.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous reset, active-low
tran_start_i  in  1  one-cycle start pulse
tran_write_i  in  1  1 = write, 0 = read; sampled with start
tran_clear_i  in  1  acknowledges the result and returns the block to idle
tran_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
tran_addr_i  in  32  byte address
tran_data_i  in  32  write data, right-aligned
tran_data_o  out  32  read data, right-aligned, zero-extended
tran_ready_o  out  1  sticky; transaction finished
tran_error_o  out  1  sticky; misaligned, reserved size, bus error or timeout
tran_timeout_o  out  1  sticky; abort was caused by timeout
busy_o  out  1  bus cycle in progress
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control
wb_adr_o  out  32  word-aligned address ({addr[31:2], 2'b00})
wb_sel_o  out  4  byte enables
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i, wb_err_i  in  1 each  slave termination

Behaviour:
- Reset (async, reset_i = 0): state IDLE; every output 0, including wb_* and tran_data_o. An in-flight cycle drops cyc/stb immediately.
- States: IDLE, BUS, DONE.
- IDLE, start = 1: latch addr, data, size and we.
  - Size 11, half with addr[0] = 1, or word with addr[1:0] != 0: go to DONE with error = 1, ready = 1. No bus cycle is issued.
  - Otherwise go to BUS. cyc/stb/we/adr/sel/dat are valid from the next cycle.
- Lane rules:
  - byte: sel = 4'b0001 << addr[1:0]; dat_o = {4{d[7:0]}}
  - half: sel = 4'b0011 << addr[1:0]; dat_o = {2{d[15:0]}}
  - word: sel = 4'b1111; dat_o = d
- Read extraction: wb_dat_i >> (8 * addr[1:0]), masked to the size, zero-extended.
- BUS: cyc/stb and all address/data/control outputs stay stable until ack_i or err_i.
  - ack: capture read data (write: tran_data_o = 0), drop cyc/stb on the same edge, go to DONE with ready = 1.
  - err: tran_data_o = 0, error = 1, ready = 1, go to DONE.
  - ack and err in the same cycle: err wins.
- Latency: start at cycle 0, stb at cycle 1, ack at cycle k, ready at cycle k+1. Zero-wait slave: ready at cycle 2.
- DONE: ready/error/timeout/data held until tran_clear_i. On clear, all status and tran_data_o go to 0 next cycle and state returns to IDLE.
- start outside IDLE: ignored, not queued.
- clear in BUS: ignored; the bus cycle must complete.
- clear and start in the same cycle in DONE: clear wins, start is dropped.
- clear and start in the same cycle in IDLE: start is accepted.
- busy_o = 1 exactly while in BUS.

Optional Feature:
EXT_TRAN_TIMEOUT_EN.
- Defined: an 8+ bit counter resets on entering BUS and increments each BUS cycle. When it reaches TIMEOUT_CYCLES with no ack/err, cyc/stb drop, error = 1, timeout = 1, ready = 1, tran_data_o = 0, and the state goes to DONE.
- Undefined: the cycle waits indefinitely, tran_timeout_o is tied 0, and no counter is synthesized.
- Port list is identical in both builds.

Decomposition:
- Package ext_tran_pkg: size encodings (SIZE_BYTE/HALF/WORD/RSVD), state encoding (ST_IDLE/ST_BUS/ST_DONE), and the misalignment predicate.
- One combinational sub-module, ext_tran_lanes: inputs size and addr[1:0]; computes sel, write replication and read extraction, and flags misalignment. Both this block and the bench reference model reuse it.

Test Plan:
- Word write addr 0x100, data 0xDEADBEEF, zero-wait ack → adr 0x100, sel 1111, we = 1, dat_o 0xDEADBEEF; ready at cycle 2, error = 0.
- Byte read addr 0x103, slave returns 0x11223344 after 3 wait states → sel 1000, tran_data_o 0x00000011, ready 5 cycles after start.
- Half write addr 0x001 → no cyc ever asserted; ready = 1, error = 1 at cycle 1. Same result for size 11 at 0x0.
- wb_err_i together with ack on a word read → error = 1, tran_data_o = 0. Then clear together with start → clear wins: idle, no new cycle.
- reset_i low for 1 cycle mid-BUS → cyc/stb low asynchronously, all status 0. A subsequent start works normally.
- With EXT_TRAN_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never acks → cyc drops after 16 BUS cycles; ready = error = timeout = 1.

Source files
------------

// File: rtl/ext_tran_pkg.sv
// ext_tran_pkg
//   Shared definitions for the external transaction master:
//   - size_t  : host transfer size encoding (byte / half / word / reserved)
//   - state_t : master FSM states
//   - is_misaligned() : true when a size/offset pair cannot be issued as a
//     single Wishbone beat (reserved size, odd half, unaligned word).
package ext_tran_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        logic bad;
        unique case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ext_tran_lanes.sv
// ext_tran_lanes
//   Combinational byte-lane steering for a 32-bit Wishbone data bus.
//   Ports:
//     size       in  transfer size (size_t)
//     offset     in  byte offset within the word (addr[1:0])
//     wdata      in  right-aligned host write data
//     bus_rdata  in  raw read data from the bus
//     sel        out byte enables
//     bus_wdata  out write data replicated across the lanes
//     rdata      out read data shifted down, masked to size, zero-extended
//     misaligned out size/offset cannot be issued
module ext_tran_lanes
    import ext_tran_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        sel        = '0;
        bus_wdata  = '0;
        rdata      = '0;
        shifted    = bus_rdata >> {offset, 3'b000};
        misaligned = is_misaligned(size, offset);
        unique case (size)
            SIZE_BYTE: begin
                sel       = 4'b0001 << offset;
                bus_wdata = {4{wdata[7:0]}};
                rdata     = {24'b0, shifted[7:0]};
            end
            SIZE_HALF: begin
                sel       = 4'b0011 << offset;
                bus_wdata = {2{wdata[15:0]}};
                rdata     = {16'b0, shifted[15:0]};
            end
            SIZE_WORD: begin
                sel       = 4'b1111;
                bus_wdata = wdata;
                rdata     = bus_rdata;
            end
            default: begin
                sel       = '0;
                bus_wdata = '0;
                rdata     = '0;
            end
        endcase
    end

endmodule

// File: rtl/ext_tran_master.sv
// ext_tran_master
//   Turns one host-programmed transaction into a single Wishbone classic
//   master cycle, with lane steering, alignment checking and sticky
//   ready/error/timeout status held until the host clears it.
//   Optional build macro: EXT_TRAN_TIMEOUT_EN (bus cycle abort after
//   TIMEOUT_CYCLES cycles without ack/err).
//   Ports:
//     clk_i, reset_i (async, active-low)
//     tran_start_i/write_i/clear_i/size_i/addr_i/data_i  host request
//     tran_data_o, tran_ready_o, tran_error_o, tran_timeout_o, busy_o
//     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o  bus master
//     wb_dat_i, wb_ack_i, wb_err_i                              bus slave response
module ext_tran_master
    import ext_tran_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  tran_start_i,
    input  logic                  tran_write_i,
    input  logic                  tran_clear_i,
    input  logic [1:0]            tran_size_i,
    input  logic [ADDR_WIDTH-1:0] tran_addr_i,
    input  logic [DATA_WIDTH-1:0] tran_data_i,
    output logic [DATA_WIDTH-1:0] tran_data_o,
    output logic                  tran_ready_o,
    output logic                  tran_error_o,
    output logic                  tran_timeout_o,
    output logic                  busy_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    size_t                   size_q;
    logic                    we_q;
    logic                    ready_q, ready_next;
    logic                    error_q, error_next;
    logic                    timeout_q, timeout_next;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_next;
    logic                    load;
    logic                    timeout_hit;
    logic                    in_bus;

    size_t                   lane_size;
    logic [1:0]              lane_offset;
    logic [3:0]              lane_sel;
    logic [31:0]             lane_wdata;
    logic [31:0]             lane_rdata;
    logic                    lane_misaligned;

    // In IDLE the lane block checks the incoming request for alignment;
    // everywhere else it steers the latched request onto the bus.
    assign lane_size   = (state == ST_IDLE) ? size_t'(tran_size_i) : size_q;
    assign lane_offset = (state == ST_IDLE) ? tran_addr_i[1:0] : addr_q[1:0];

    ext_tran_lanes u_lanes (
        .size       (lane_size),
        .offset     (lane_offset),
        .wdata      (wdata_q),
        .bus_rdata  (wb_dat_i),
        .sel        (lane_sel),
        .bus_wdata  (lane_wdata),
        .rdata      (lane_rdata),
        .misaligned (lane_misaligned)
    );

`ifdef EXT_TRAN_TIMEOUT_EN
    localparam int unsigned TmoWidth =
        (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TmoWidth-1:0] tmo_count;

    // Counts completed BUS cycles; cleared whenever the FSM is outside BUS.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_count <= '0;
        end else if (state != ST_BUS) begin
            tmo_count <= '0;
        end else begin
            tmo_count <= tmo_count + TmoWidth'(1);
        end
    end

    assign timeout_hit = (state == ST_BUS) && (tmo_count == TmoWidth'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        ready_next   = ready_q;
        error_next   = error_q;
        timeout_next = timeout_q;
        rdata_next   = rdata_q;
        load         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tran_start_i) begin
                    load = 1'b1;
                    if (lane_misaligned) begin
                        state_next = ST_DONE;
                        ready_next = 1'b1;
                        error_next = 1'b1;
                    end else begin
                        state_next = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (wb_err_i) begin
                    state_next = ST_DONE;
                    ready_next = 1'b1;
                    error_next = 1'b1;
                    rdata_next = '0;
                end else if (wb_ack_i) begin
                    state_next = ST_DONE;
                    ready_next = 1'b1;
                    rdata_next = we_q ? '0 : lane_rdata;
                end else if (timeout_hit) begin
                    state_next   = ST_DONE;
                    ready_next   = 1'b1;
                    error_next   = 1'b1;
                    timeout_next = 1'b1;
                    rdata_next   = '0;
                end
            end
            ST_DONE: begin
                if (tran_clear_i) begin
                    state_next   = ST_IDLE;
                    ready_next   = 1'b0;
                    error_next   = 1'b0;
                    timeout_next = 1'b0;
                    rdata_next   = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SIZE_BYTE;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state     <= state_next;
            ready_q   <= ready_next;
            error_q   <= error_next;
            timeout_q <= timeout_next;
            rdata_q   <= rdata_next;
            if (load) begin
                addr_q  <= tran_addr_i;
                wdata_q <= tran_data_i;
                size_q  <= size_t'(tran_size_i);
                we_q    <= tran_write_i;
            end
        end
    end

    // Bus outputs are decoded from the state so an async reset drops them
    // immediately and they read as zero outside a bus cycle.
    assign in_bus         = (state == ST_BUS);
    assign busy_o         = in_bus;
    assign wb_cyc_o       = in_bus;
    assign wb_stb_o       = in_bus;
    assign wb_we_o        = in_bus & we_q;
    assign wb_adr_o       = in_bus ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign wb_sel_o       = in_bus ? lane_sel : '0;
    assign wb_dat_o       = in_bus ? lane_wdata : '0;
    assign tran_data_o    = rdata_q;
    assign tran_ready_o   = ready_q;
    assign tran_error_o   = error_q;
    assign tran_timeout_o = timeout_q;

endmodule
